pq_req_adapter: RTL
===================

# pq_req_adapter

Request adapter between streaming producers/consumers and the shift-register priority queue (`pq_if`). It sits directly upstream of the queue:
- buffers enqueue requests in a small FIFO;
- holds one pending dequeue request;
- sequences `enq`, `deq` and simultaneous `enq+deq` pulses while honouring `busy`, `full` and `empty`;
- returns dequeued key/value pairs on a valid/ready output.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: enqueue FIFO entries; power of two, ≥2.
- `KV_WIDTH`, `KEY_WIDTH+VAL_WIDTH`: width of one key/value pair; taken from `pq_pkg`.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `enq_valid`  in  1  producer has a pair.
- `enq_ready`  out  1  `= !fifo_full`.
- `enq_kv`  in  KV_WIDTH  `{key,val}`.
- `deq_valid`  in  1  consumer requests one dequeue.
- `deq_ready`  out  1  `= !deq_pend && !out_valid`.
- `out_valid`  out  1  dequeued pair is held.
- `out_ready`  in  1  consumer accepts the pair.
- `out_kv`  out  KV_WIDTH  dequeued `{key,val}`.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- `pq_enq`, `pq_deq`  out  1  one-cycle command pulses to the queue.
- `pq_kvi`  out  KV_WIDTH  enqueue data; valid while `pq_enq` is high.
- `pq_kvo`  in  KV_WIDTH  current queue head; valid while `!pq_empty`.
- `pq_busy`, `pq_full`, `pq_empty`  in  1  queue status.

## Operation
- Reset values: `pq_enq`=0, `pq_deq`=0, `pq_kvi`=0, `out_valid`=0, `out_kv`=0, `fifo_count`=0, `enq_ready`=1, `deq_ready`=1, `deq_pend`=0, state=IDLE.
- Enqueue handshake: `enq_valid && enq_ready` writes `enq_kv` to the FIFO tail.
- Dequeue handshake: `deq_valid && deq_ready` sets `deq_pend`.
- FSM states: IDLE → ISSUE → SETTLE → WAIT → IDLE.
  - IDLE: requires `!pq_busy`. Selects the operation in this priority order, otherwise stays in IDLE:
    - BOTH: only with the combine macro, when `deq_pend && !pq_empty && fifo nonempty`.
    - DEQ: when `deq_pend && !pq_empty`.
    - ENQ: when `fifo nonempty && !pq_full`.
  - ISSUE: asserts `pq_enq` and/or `pq_deq` for exactly one cycle.
    - `pq_kvi` = FIFO head; the FIFO is popped on ENQ or BOTH.
    - On DEQ or BOTH: captures `pq_kvo` into `out_kv`, sets `out_valid`, clears `deq_pend`.
  - SETTLE: one cycle; `busy` is ignored.
  - WAIT: stays while `pq_busy`; goes to IDLE on the first cycle with `pq_busy`=0.
- `out_valid` holds until `out_ready`. `deq_ready` stays low meanwhile, so at most one dequeued result is outstanding.
- Boundary conditions:
  - `pq_full`: ENQ stalls. DEQ and BOTH remain legal.
  - `pq_empty` with a pending dequeue: the request waits. It is never an error and never issued.
  - FIFO full: `enq_ready`=0. A push and a pop in the same cycle keep the count unchanged; the pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation: `rst_n`=0 aborts any state, flushes the FIFO, drops `deq_pend` and `out_valid`, and drives the pulses low at that edge. The queue itself is reset by the system.

## Timing
- Enqueue latency: a handshake in cycle N, with the FSM idle and the queue ready, gives `pq_enq`=1 in cycle N+2.
- Dequeue latency: a handshake in cycle N gives `pq_deq`=1 in cycle N+2 and `out_valid`=1 in cycle N+3.
- Back-to-back queue commands are at least 4 cycles apart (ISSUE, SETTLE, WAIT, IDLE); more if `pq_busy` stays high.
- All outputs are registered except `enq_ready` and `deq_ready`, which are decoded from registers.

## Configuration
- `PQ_ADAPT_COMBINE_EN` defined: a pending dequeue plus a nonempty FIFO issue a single BOTH command (`pq_enq`=`pq_deq`=1). This is legal even when `pq_full`.
- `PQ_ADAPT_COMBINE_EN` undefined: BOTH is never issued. DEQ is issued first, then ENQ in a later IDLE.

## Structure
- `pq_pkg` adds the following; `KEY_WIDTH` and `VAL_WIDTH` already exist there:
  - `typedef logic [KEY_WIDTH+VAL_WIDTH-1:0] kv_t;`
  - `typedef enum {IDLE, ISSUE, SETTLE, WAIT} adapt_state_t;`
  - `typedef enum {OP_ENQ, OP_DEQ, OP_BOTH} pq_op_t;`
- Sub-module `pq_req_fifo`: synchronous FIFO of `kv_t` with parameter `FIFO_DEPTH`, outputs `count`, `full`, `empty`.

## Test plan
- Reset, then enqueue (5,3), (10,1), (3,4) back-to-back → three `pq_enq` pulses ≥4 cycles apart, with `pq_kvi` in arrival order; `fifo_count` peaks at 2.
- Queue model holds min (3,4); a dequeue request → one `pq_deq` pulse, `out_kv`={3,4}, `out_valid` held 5 cycles until `out_ready`, `deq_ready`=0 throughout.
- `pq_full`=1 and 5 enqueues offered → FIFO holds 4, `enq_ready`=0, no `pq_enq`; deassert `pq_full` → four pulses in order.
- Macro defined, queue nonempty, simultaneous enqueue (9,9) and dequeue → one cycle with `pq_enq`=`pq_deq`=1. Macro undefined → `pq_deq` first, `pq_enq` later.
- `pq_empty`=1 and a dequeue requested → no `pq_deq` for 20 cycles; after one enqueue completes, the dequeue issues.
- `rst_n`=0 during WAIT with 3 FIFO entries → next cycle `fifo_count`=0, `out_valid`=0, state IDLE, no pulses.

Source files
------------

// File: rtl/pq_pkg.sv
// pq_pkg: shared types for the shift-register priority queue and its
// request adapter.
//   KEY_WIDTH / VAL_WIDTH : widths of one key and one value
//   kv_t                  : packed {key, val} pair, key in the MSBs
//   adapt_state_t         : adapter sequencing FSM states
//   pq_op_t               : command the adapter issues to the queue
package pq_pkg;

  localparam int KEY_WIDTH = 8;
  localparam int VAL_WIDTH = 8;

  typedef logic [KEY_WIDTH+VAL_WIDTH-1:0] kv_t;

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, WAIT} adapt_state_t;

  typedef enum logic [1:0] {OP_ENQ, OP_DEQ, OP_BOTH} pq_op_t;

endpackage

// File: rtl/pq_req_fifo.sv
// pq_req_fifo: synchronous FIFO of kv_t pairs buffering enqueue requests.
//   clk, rst_n : clock, synchronous active-low reset (flushes the FIFO)
//   push, din  : write din at the tail (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   head       : current head entry, meaningful while !empty
//   count      : occupancy 0..FIFO_DEPTH
//   full/empty : occupancy flags
module pq_req_fifo
  import pq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  kv_t                         din,
  input  logic                        pop,
  output kv_t                         head,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        full,
  output logic                        empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  kv_t            mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           push_ok, pop_ok;

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok) count_d = count_q + 1'b1;
    else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/pq_req_adapter.sv
// pq_req_adapter: request adapter in front of the shift-register priority
// queue. Buffers enqueue pairs in a FIFO, holds one pending dequeue, and
// sequences enq / deq (/ combined) command pulses to the queue while
// honouring its busy/full/empty status. Dequeued pairs are returned on a
// valid/ready output.
//
// Build option: define PQ_ADAPT_COMBINE_EN to allow a single combined
// enq+deq command when a dequeue is pending and the FIFO is nonempty.
//
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   enq_valid/ready/kv    : enqueue stream in ({key,val})
//   deq_valid/ready       : one-shot dequeue request
//   out_valid/ready/kv    : dequeued pair out
//   fifo_count            : enqueue FIFO occupancy
//   pq_enq, pq_deq, pq_kvi: registered one-cycle commands to the queue
//   pq_kvo                : queue head
//   pq_busy/full/empty    : queue status
//
// state  | meaning
// IDLE   | waiting for !pq_busy and a legal operation
// ISSUE  | command pulse on pq_enq/pq_deq; head captured on dequeue
// SETTLE | one cycle for the queue to raise busy; busy ignored
// WAIT   | hold until the queue drops busy
module pq_req_adapter
  import pq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int KV_WIDTH   = KEY_WIDTH + VAL_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enq_valid,
  output logic                        enq_ready,
  input  logic [KV_WIDTH-1:0]         enq_kv,
  input  logic                        deq_valid,
  output logic                        deq_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [KV_WIDTH-1:0]         out_kv,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        pq_enq,
  output logic                        pq_deq,
  output logic [KV_WIDTH-1:0]         pq_kvi,
  input  logic [KV_WIDTH-1:0]         pq_kvo,
  input  logic                        pq_busy,
  input  logic                        pq_full,
  input  logic                        pq_empty
);

`ifdef PQ_ADAPT_COMBINE_EN
  localparam bit COMBINE_EN = 1'b1;
`else
  localparam bit COMBINE_EN = 1'b0;
`endif

  adapt_state_t state_q, state_d;
  pq_op_t       op_q, op_d;
  logic         pq_enq_q, pq_enq_d;
  logic         pq_deq_q, pq_deq_d;
  kv_t          pq_kvi_q, pq_kvi_d;
  logic         out_valid_q, out_valid_d;
  kv_t          out_kv_q, out_kv_d;
  logic         deq_pend_q, deq_pend_d;

  kv_t          fifo_head;
  logic         fifo_full, fifo_empty, fifo_push, fifo_pop;

  assign enq_ready  = !fifo_full;
  assign deq_ready  = !deq_pend_q && !out_valid_q;
  assign fifo_push  = enq_valid && enq_ready;
  assign out_valid  = out_valid_q;
  assign out_kv     = out_kv_q;
  assign pq_enq     = pq_enq_q;
  assign pq_deq     = pq_deq_q;
  assign pq_kvi     = pq_kvi_q;

  pq_req_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (enq_kv),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    pq_enq_d    = 1'b0;
    pq_deq_d    = 1'b0;
    pq_kvi_d    = pq_kvi_q;
    out_valid_d = out_valid_q;
    out_kv_d    = out_kv_q;
    deq_pend_d  = deq_pend_q;
    fifo_pop    = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (deq_valid && deq_ready)   deq_pend_d  = 1'b1;

    case (state_q)
      IDLE: begin
        // The pulses are registered, so the operation is chosen here and
        // the FIFO head is popped into pq_kvi on the way into ISSUE.
        if (!pq_busy) begin
          if (COMBINE_EN && deq_pend_q && !pq_empty && !fifo_empty) begin
            op_d = OP_BOTH;
            state_d = ISSUE;
          end else if (deq_pend_q && !pq_empty) begin
            op_d = OP_DEQ;
            state_d = ISSUE;
          end else if (!fifo_empty && !pq_full) begin
            op_d = OP_ENQ;
            state_d = ISSUE;
          end
          if (state_d == ISSUE) begin
            pq_enq_d = (op_d != OP_DEQ);
            pq_deq_d = (op_d != OP_ENQ);
            if (pq_enq_d) begin
              pq_kvi_d = fifo_head;
              fifo_pop = 1'b1;
            end
          end
        end
      end
      ISSUE: begin
        // Queue head is still the pre-dequeue value during the pulse.
        if (op_q != OP_ENQ) begin
          out_kv_d    = pq_kvo;
          out_valid_d = 1'b1;
          deq_pend_d  = 1'b0;
        end
        state_d = SETTLE;
      end
      SETTLE: state_d = WAIT;
      WAIT:   if (!pq_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_ENQ;
      pq_enq_q    <= 1'b0;
      pq_deq_q    <= 1'b0;
      pq_kvi_q    <= '0;
      out_valid_q <= 1'b0;
      out_kv_q    <= '0;
      deq_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      pq_enq_q    <= pq_enq_d;
      pq_deq_q    <= pq_deq_d;
      pq_kvi_q    <= pq_kvi_d;
      out_valid_q <= out_valid_d;
      out_kv_q    <= out_kv_d;
      deq_pend_q  <= deq_pend_d;
    end
  end

endmodule
